// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic write arbiter that merges NUM_REQ requesters into a single FIFO write port.
// Define FIFO_WR_ARBITER_STATS_EN to add per-requester accepted-word counters (stat_sel/stat_cnt).
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      res_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      fifo_full,
  output logic                      shift_in,
  output logic [DATA_W-1:0]         data_in
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
  output logic [15:0]                stat_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] rr_winner;
  logic             rr_found;
  logic [DATA_W-1:0] words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    rr_found  = 1'b0;
    rr_winner = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_winner) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!rr_found && req[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

  always_comb begin
    ack     = '0;
    data_in = '0;
    if (state == BUSY) begin
      ack[grant_idx] = req[grant_idx] & ~fifo_full;
      data_in        = words[grant_idx];
    end
    shift_in = |ack;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      last_winner <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (rr_found) begin
            grant     <= NUM_REQ'(1) << rr_winner;
            grant_idx <= rr_winner;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Grant is released only on an accepted last word; nothing preempts a packet.
          if (ack[grant_idx] && req_last[grant_idx]) begin
            last_winner <= grant_idx;
            grant       <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] word_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < NUM_REQ; i++) word_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] && word_cnt[i] != 16'hFFFF) word_cnt[i] <= word_cnt[i] + 16'd1;
      end
    end
  end

  assign stat_cnt = (int'(stat_sel) < NUM_REQ) ? word_cnt[stat_sel] : 16'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: scoreboard of expected (data, grant) words popped on every shift_in.
// Also checks the stats counters when FIFO_WR_ARBITER_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  logic         clk;
  logic         res_n;
  logic [3:0]   req;
  logic [3:0]   req_last;
  logic [255:0] req_data;
  logic [3:0]   ack;
  logic [3:0]   grant;
  logic         fifo_full;
  logic         shift_in;
  logic [63:0]  data_in;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [1:0]   stat_sel;
  logic [15:0]  stat_cnt;
`endif

  typedef struct {
    logic [63:0] data;
    logic [3:0]  grant;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(64)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .req       (req),
    .req_last  (req_last),
    .req_data  (req_data),
    .ack       (ack),
    .grant     (grant),
    .fifo_full (fifo_full),
    .shift_in  (shift_in),
    .data_in   (data_in)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every accepted word must be the next one the stimulus predicted, under the predicted grant.
  always @(negedge clk) begin
    if (res_n && shift_in) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL scoreboard_unexpected: got data_in=%h grant=%b, required no word", data_in, grant);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data_in !== e.data || grant !== e.grant) begin
          miscompares++;
          $display("[TB] FAIL scoreboard_word: got data_in=%h grant=%b, required data_in=%h grant=%b",
                   data_in, grant, e.data, e.grant);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    res_n     = 1'b0;
    req       = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 res_n = 1'b1;
    tick();
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    res_n     = 1'b0;
    req       = 4'b1111;
    req_last  = 4'b1111;
    req_data  = {4{64'hDEAD_BEEF_0000_0001}};
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL reset_grant: got %b, required 0000", grant);
    end
    vectors++;
    if (ack !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL reset_ack: got %b, required 0000", ack);
    end
    vectors++;
    if (shift_in !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_shift_in: got %b, required 0", shift_in);
    end
    vectors++;
    if (data_in !== 64'h0) begin
      miscompares++; $display("[TB] FAIL reset_data_in: got %h, required 0", data_in);
    end
    apply_reset();
  endtask

  task automatic test_single_word();
    req      = 4'b0001;
    req_last = 4'b0001;
    req_data[0 +: 64] = 64'h1;
    exp_q.push_back('{64'h1, 4'b0001});
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0000 || shift_in !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_idle: got grant=%b shift_in=%b, required 0000/0", grant, shift_in);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0001 || shift_in !== 1'b1 || data_in !== 64'h1) begin
      miscompares++;
      $display("[TB] FAIL single_busy: got grant=%b shift_in=%b data_in=%h, required 0001/1/1",
               grant, shift_in, data_in);
    end
    tick();
    req      = '0;
    req_last = '0;
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0000 || shift_in !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_return_idle: got grant=%b shift_in=%b, required 0000/0", grant, shift_in);
    end
    tick();
    check_drained("single");
  endtask

  task automatic test_round_robin();
    apply_reset();
    req      = 4'b1111;
    req_last = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = 64'h100 + 64'(i);
    for (int k = 0; k < 8; k++) exp_q.push_back('{64'h100 + 64'(k % 4), 4'(1 << (k % 4))});
    for (int c = 0; c < 16; c++) begin
      logic       exp_shift;
      logic [3:0] exp_grant;
      exp_shift = (c % 2 == 1);
      exp_grant = exp_shift ? 4'(1 << ((c / 2) % 4)) : 4'b0000;
      @(negedge clk);
      vectors++;
      if (shift_in !== exp_shift || grant !== exp_grant) begin
        miscompares++;
        $display("[TB] FAIL rr_cycle%0d: got shift_in=%b grant=%b, required %b/%b",
                 c, shift_in, grant, exp_shift, exp_grant);
      end
      tick();
    end
    req      = '0;
    req_last = '0;
    tick();
    check_drained("rr");
  endtask

`ifdef FIFO_WR_ARBITER_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 4; i++) begin
      stat_sel = 2'(i);
      #1;
      vectors++;
      if (stat_cnt !== 16'd2) begin
        miscompares++;
        $display("[TB] FAIL stats_req%0d: got %0d, required 2", i, stat_cnt);
      end
    end
  endtask
`endif

  task automatic test_packet_atomic();
    logic [7:0] pat;
    int         w1;
    apply_reset();
    pat      = 8'b0010_1110;
    w1       = 0;
    req      = 4'b0110;
    req_last = 4'b0100;
    req_data[64 +: 64]  = 64'h10;
    req_data[128 +: 64] = 64'h20;
    exp_q.push_back('{64'h10, 4'b0010});
    exp_q.push_back('{64'h11, 4'b0010});
    exp_q.push_back('{64'h12, 4'b0010});
    exp_q.push_back('{64'h20, 4'b0100});
    for (int c = 0; c < 8; c++) begin
      logic a1, a2;
      @(negedge clk);
      a1 = ack[1];
      a2 = ack[2];
      vectors++;
      if (shift_in !== pat[c]) begin
        miscompares++;
        $display("[TB] FAIL atomic_cycle%0d: got shift_in=%b, required %b", c, shift_in, pat[c]);
      end
      tick();
      if (a1) begin
        w1++;
        if (w1 == 3) begin
          req[1] = 1'b0; req_last[1] = 1'b0;
        end else begin
          req_data[64 +: 64] = 64'h10 + 64'(w1);
          if (w1 == 2) req_last[1] = 1'b1;
        end
      end
      if (a2) begin
        req[2] = 1'b0; req_last[2] = 1'b0;
      end
    end
    check_drained("atomic");
  endtask

  task automatic test_fifo_full();
    logic [7:0] shift_pat, grant_pat;
    int         w0;
    apply_reset();
    shift_pat = 8'b0011_0000;
    grant_pat = 8'b0011_1110;
    w0        = 0;
    req       = 4'b0001;
    req_data[0 +: 64] = 64'h30;
    exp_q.push_back('{64'h30, 4'b0001});
    exp_q.push_back('{64'h31, 4'b0001});
    for (int c = 0; c < 8; c++) begin
      logic a0;
      fifo_full = (c >= 1 && c <= 3);
      @(negedge clk);
      a0 = ack[0];
      vectors++;
      if (shift_in !== shift_pat[c] || grant !== {3'b000, grant_pat[c]}) begin
        miscompares++;
        $display("[TB] FAIL full_cycle%0d: got shift_in=%b grant=%b, required %b/%b",
                 c, shift_in, grant, shift_pat[c], {3'b000, grant_pat[c]});
      end
      tick();
      if (a0) begin
        w0++;
        if (w0 == 2) begin
          req = '0; req_last = '0;
        end else begin
          req_data[0 +: 64] = 64'h31; req_last[0] = 1'b1;
        end
      end
    end
    fifo_full = 1'b0;
    check_drained("full");
  endtask

  task automatic test_req_gap();
    logic [7:0] shift_pat, grant_pat;
    int         w2;
    apply_reset();
    shift_pat = 8'b0000_1010;
    grant_pat = 8'b0000_1110;
    w2        = 0;
    req_data[128 +: 64] = 64'h40;
    exp_q.push_back('{64'h40, 4'b0100});
    exp_q.push_back('{64'h41, 4'b0100});
    for (int c = 0; c < 6; c++) begin
      logic a2;
      req[2] = (c != 2) && (w2 < 2);
      @(negedge clk);
      a2 = ack[2];
      vectors++;
      if (shift_in !== shift_pat[c] || grant !== {1'b0, grant_pat[c], 2'b00}) begin
        miscompares++;
        $display("[TB] FAIL gap_cycle%0d: got shift_in=%b grant=%b, required %b/%b",
                 c, shift_in, grant, shift_pat[c], {1'b0, grant_pat[c], 2'b00});
      end
      tick();
      if (a2) begin
        w2++;
        req_data[128 +: 64] = 64'h41;
        req_last[2] = 1'b1;
      end
    end
    req = '0; req_last = '0;
    check_drained("gap");
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    req      = 4'b1000;
    req_last = 4'b0000;
    req_data[192 +: 64] = 64'h50;
    exp_q.push_back('{64'h50, 4'b1000});
    @(negedge clk);
    tick();
    @(negedge clk);
    vectors++;
    if (shift_in !== 1'b1 || grant !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL midrst_first_word: got shift_in=%b grant=%b, required 1/1000", shift_in, grant);
    end
    tick();
    req_data[192 +: 64] = 64'h51;
    res_n = 1'b0;
    #1;
    vectors++;
    if (grant !== 4'b0000 || ack !== 4'b0000 || shift_in !== 1'b0 || data_in !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: got grant=%b ack=%b shift_in=%b data_in=%h, required all zero",
               grant, ack, shift_in, data_in);
    end
    req      = 4'b1010;
    req_last = 4'b0010;
    req_data[64 +: 64] = 64'h60;
    exp_q.push_back('{64'h60, 4'b0010});
    #2 res_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0000 || shift_in !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_idle: got grant=%b shift_in=%b, required 0000/0", grant, shift_in);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0010 || shift_in !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_regrant: got grant=%b shift_in=%b, required 0010/1", grant, shift_in);
    end
    tick();
    req = '0; req_last = '0;
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0000 || shift_in !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_done: got grant=%b shift_in=%b, required 0000/0", grant, shift_in);
    end
    tick();
    check_drained("midrst");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef FIFO_WR_ARBITER_STATS_EN
    stat_sel = '0;
`endif
    test_reset();
    test_single_word();
    test_round_robin();
`ifdef FIFO_WR_ARBITER_STATS_EN
    test_stats();
`endif
    test_packet_atomic();
    test_fifo_full();
    test_req_gap();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
